// File: rtl/uart_pkg.sv
// Shared UART receive definitions: deframer states, data width, baud divisor helper.
// No logic; used by the deframer and its bench.
// No backpressure; constants only.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } rx_state_e;

    // Clock cycles per oversample tick, truncated.
    function automatic int calc_divisor(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head word is visible on dout_o whenever not empty.
// Latency: push in cycle N is visible at dout_o in cycle N+1 when previously empty.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty hides them.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive front-end: oversampled 8N1 deframer (8E1 with UART_RX_PARITY_EN) feeding a FWFT byte FIFO.
// Latency: byte appears on rx_data/rx_done two cycles after the mid-stop-bit sample (FIFO empty).
// Backpressure: none toward the line; a good byte arriving at a full FIFO is dropped and flagged on overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 overflow
);
    localparam int DIV   = calc_divisor(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW    = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SW-1:0]    SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]    SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_meta_q;
    logic                 rx_sync_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic                 tick;
    rx_state_e            state_q;
    logic [SW-1:0]        samp_cnt_q;
    logic [2:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 push_q;
    logic                 frame_err_q;
    logic                 overflow_q;
    logic                 stop_ok;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

`ifdef UART_RX_PARITY_EN
    logic par_q;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign stop_ok = rx_sync_q && !(^{shift_q, par_q});
`else
    assign stop_ok = rx_sync_q;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);

    // Deframer: find start edge, re-check at mid-start, then sample every bit at its centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (!rx_sync_q) begin
                            state_q    <= START;
                            samp_cnt_q <= '0;
                        end
                    end
                    START: begin
                        if (samp_cnt_q == SAMP_MID) begin
                            // A line back high at mid-start was a glitch, not a frame.
                            if (!rx_sync_q) begin
                                state_q    <= DATA;
                                samp_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            samp_cnt_q <= '0;
                            shift_q    <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            samp_cnt_q <= '0;
                            par_q      <= rx_sync_q;
                            state_q    <= STOP;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            // Back to IDLE at mid-stop so a following start edge is not missed.
                            state_q <= IDLE;
                            if (stop_ok) push_q      <= 1'b1;
                            else         frame_err_q <= 1'b1;
                        end else begin
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Drop flag: a push into a full FIFO with no simultaneous pop loses the byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q && fifo_full && !rd_en;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_q),
        .din_i   (shift_q),
        .pop_i   (rd_en),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Empty FIFO presents zero rather than stale storage.
    assign rx_data   = fifo_empty ? '0 : fifo_dout;
    assign rx_done   = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
